// File: rtl/decode_queue_if.sv
// Handshake bundle between fetch (master) and the decode queue (slave).
// Carries the enqueue group, the dequeue request and the occupancy/perf outputs.
interface decode_queue_if #(
    parameter int DEC_WIDTH = 2,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 32
);
    localparam int BUNDLE_W = ADDR_W + 77;
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int DQ_W     = $clog2(DEC_WIDTH + 1);

    logic                          kill_i;
    logic [DEC_WIDTH-1:0]          in_valid_i;
    logic [DEC_WIDTH*32-1:0]       in_inst_i;
    logic [DEC_WIDTH*ADDR_W-1:0]   in_pc_i;
    logic                          in_ready_o;
    logic [DEC_WIDTH-1:0]          out_valid_o;
    logic [DEC_WIDTH*BUNDLE_W-1:0] out_bundle_o;
    logic [DQ_W-1:0]               deq_cnt_i;
    logic [CNT_W-1:0]              count_o;
    logic [31:0]                   stall_cycles_o;
    logic [31:0]                   empty_cycles_o;

    modport slave (
        input  kill_i, in_valid_i, in_inst_i, in_pc_i, deq_cnt_i,
        output in_ready_o, out_valid_o, out_bundle_o, count_o,
        stall_cycles_o, empty_cycles_o
    );

    modport master (
        output kill_i, in_valid_i, in_inst_i, in_pc_i, deq_cnt_i,
        input  in_ready_o, out_valid_o, out_bundle_o, count_o,
        stall_cycles_o, empty_cycles_o
    );
endinterface

// File: rtl/decode_queue.sv
// Multi-lane RISC-V decode followed by a circular bundle queue with group enqueue/dequeue.
// Optional perf counters are enabled by defining DECODE_QUEUE_PERF_EN.
module decode_queue #(
    parameter int DEC_WIDTH = 2,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 32
) (
    input logic           clk_i,
    input logic           reset_i,
    decode_queue_if.slave q
);
    localparam int BUNDLE_W = ADDR_W + 77;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_OP_IMM = 7'b0010011, OPC_OP = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111, OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
    localparam logic [1:0] SRC_A_RS1 = 2'd0, SRC_A_PC = 2'd1, SRC_A_ZERO = 2'd2;
    localparam logic [1:0] SRC_B_RS2 = 2'd0, SRC_B_IMM = 2'd1, SRC_B_FOUR = 2'd2;
    localparam logic [2:0] RS_ALU = 3'd0, RS_MUL = 3'd1, RS_DIV = 3'd2, RS_LDST = 3'd3, RS_BR = 3'd4;

    logic [BUNDLE_W-1:0] lane_bundle [DEC_WIDTH];
    logic [BUNDLE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    head_reg, tail_reg;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [CNT_W-1:0]    n_enq, n_deq;
    logic                in_ready, fire, run;

    genvar gi;
    for (gi = 0; gi < DEC_WIDTH; gi++) begin : g_lane
        logic [31:0] inst, imm;
        logic [6:0]  opc;
        logic [2:0]  f3, imm_type, rs_ent;
        logic [1:0]  src_a_sel, src_b_sel, md_op, md_out_sel;
        logic [3:0]  alu_op;
        logic        is_m, wr_reg, uses_rs1, uses_rs2, illegal, md_s1, md_s2;

        assign inst = q.in_inst_i[32*gi +: 32];
        assign opc  = inst[6:0];
        assign f3   = inst[14:12];
        assign is_m = (opc == OPC_OP) && (inst[31:25] == 7'b0000001);

        always_comb begin
            imm_type  = IMM_I;
            src_a_sel = SRC_A_RS1;
            src_b_sel = SRC_B_IMM;
            wr_reg    = 1'b0;
            uses_rs1  = 1'b0;
            uses_rs2  = 1'b0;
            illegal   = 1'b0;
            alu_op    = 4'd0;
            rs_ent    = RS_ALU;
            case (opc)
                OPC_LUI:    begin imm_type = IMM_U; src_a_sel = SRC_A_ZERO; wr_reg = 1'b1; end
                OPC_AUIPC:  begin imm_type = IMM_U; src_a_sel = SRC_A_PC; wr_reg = 1'b1; end
                OPC_JAL:    begin imm_type = IMM_J; src_a_sel = SRC_A_PC; src_b_sel = SRC_B_FOUR;
                                  wr_reg = 1'b1; rs_ent = RS_BR; end
                OPC_JALR:   begin src_a_sel = SRC_A_PC; src_b_sel = SRC_B_FOUR; wr_reg = 1'b1;
                                  uses_rs1 = 1'b1; rs_ent = RS_BR; end
                OPC_BRANCH: begin imm_type = IMM_B; src_b_sel = SRC_B_RS2; uses_rs1 = 1'b1;
                                  uses_rs2 = 1'b1; alu_op = {1'b1, f3}; rs_ent = RS_BR; end
                OPC_LOAD:   begin wr_reg = 1'b1; uses_rs1 = 1'b1; rs_ent = RS_LDST; end
                OPC_STORE:  begin imm_type = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; rs_ent = RS_LDST; end
                OPC_OP_IMM: begin wr_reg = 1'b1; uses_rs1 = 1'b1; alu_op = {(f3 == 3'b101) & inst[30], f3}; end
                OPC_OP:     begin wr_reg = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; src_b_sel = SRC_B_RS2;
                                  alu_op = {inst[30], f3};
                                  if (is_m) rs_ent = f3[2] ? RS_DIV : RS_MUL; end
                OPC_MISC_MEM, OPC_SYSTEM: ;
                default:    illegal = 1'b1;
            endcase
        end

        // Immediate decoder: reassembles the scattered immediate bits by format.
        always_comb begin
            case (imm_type)
                IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                IMM_U:   imm = {inst[31:12], 12'b0};
                IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                default: imm = {{20{inst[31]}}, inst[31:20]};
            endcase
        end

        // M-extension request: op 0=mul 1=div 2=rem; out_sel 1 selects the high product half.
        always_comb begin
            md_op      = 2'd0;
            md_s1      = 1'b0;
            md_s2      = 1'b0;
            md_out_sel = 2'd0;
            if (is_m) begin
                md_op      = f3[2] ? (f3[1] ? 2'd2 : 2'd1) : 2'd0;
                md_s1      = (f3 != 3'b011) && (f3 != 3'b101) && (f3 != 3'b111);
                md_s2      = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
                md_out_sel = (!f3[2] && (f3 != 3'b000)) ? 2'd1 : 2'd0;
            end
        end

        assign lane_bundle[gi] = {q.in_pc_i[ADDR_W*gi +: ADDR_W], imm_type, imm,
                                  inst[19:15], inst[24:20], inst[11:7], src_a_sel, src_b_sel,
                                  wr_reg, uses_rs1, uses_rs2, illegal, alu_op, rs_ent,
                                  {1'b0, f3[1:0]}, f3, md_op, md_s1, md_s2, md_out_sel};

        assign q.out_bundle_o[BUNDLE_W*gi +: BUNDLE_W] = mem[head_reg + PTR_W'(gi)];
        assign q.out_valid_o[gi] = count_reg > CNT_W'(gi);
    end

    // Only the contiguous run of valid lanes starting at lane 0 is enqueued.
    always_comb begin
        n_enq = '0;
        run   = 1'b1;
        for (int k = 0; k < DEC_WIDTH; k++) begin
            run = run & q.in_valid_i[k];
            if (run) n_enq = n_enq + CNT_W'(1);
        end
    end

    always_comb begin
        n_deq = CNT_W'(q.deq_cnt_i);
        if (count_reg < n_deq) n_deq = count_reg;
        if (n_deq > CNT_W'(DEC_WIDTH)) n_deq = CNT_W'(DEC_WIDTH);
    end

    assign in_ready   = count_reg <= CNT_W'(DEPTH - DEC_WIDTH);
    assign fire       = in_ready && (n_enq != '0);
    assign count_next = count_reg + (fire ? n_enq : '0) - n_deq;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (q.kill_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (fire) tail_reg <= tail_reg + PTR_W'(n_enq);
            head_reg  <= head_reg + PTR_W'(n_deq);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fire && !q.kill_i) begin
            for (int k = 0; k < DEC_WIDTH; k++) begin
                if (CNT_W'(k) < n_enq) mem[tail_reg + PTR_W'(k)] <= lane_bundle[k];
            end
        end
    end

    assign q.in_ready_o = in_ready;
    assign q.count_o    = count_reg;

`ifdef DECODE_QUEUE_PERF_EN
    logic [31:0] stall_reg, empty_reg;

    // Counters survive kill so flush-heavy phases still show up in the totals.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stall_reg <= '0;
            empty_reg <= '0;
        end else begin
            if (q.in_valid_i[0] && !in_ready && !q.kill_i) stall_reg <= stall_reg + 32'd1;
            if (count_reg == '0) empty_reg <= empty_reg + 32'd1;
        end
    end

    assign q.stall_cycles_o = stall_reg;
    assign q.empty_cycles_o = empty_reg;
`else
    assign q.stall_cycles_o = '0;
    assign q.empty_cycles_o = '0;
`endif
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (DEC_WIDTH=2, DEPTH=8); perf counter checks follow
// DECODE_QUEUE_PERF_EN.
module tb_decode_queue;
    localparam int BW = 109;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [BW-1:0] b0, b1;

    always #5 clk = ~clk;

    decode_queue_if #(.DEC_WIDTH(2), .DEPTH(8), .ADDR_W(32)) bus ();

    decode_queue #(.DEC_WIDTH(2), .DEPTH(8), .ADDR_W(32)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .q       (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        b0 = bus.out_bundle_o[BW-1:0];
        b1 = bus.out_bundle_o[2*BW-1:BW];
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.kill_i     = 1'b0;
        bus.in_valid_i = 2'b00;
        bus.in_inst_i  = '0;
        bus.in_pc_i    = '0;
        bus.deq_cnt_i  = '0;
        #12;
        check("reset count", 64'(bus.count_o), 64'd0);
        check("reset out_valid", 64'(bus.out_valid_o), 64'd0);
        check("reset in_ready", 64'(bus.in_ready_o), 64'd1);
        rst_n = 1'b1;

        // Group 0: ADDI x1,x0,5 and ADD x3,x1,x2
        bus.in_valid_i = 2'b11;
        bus.in_inst_i  = {32'h002081B3, 32'h00500093};
        bus.in_pc_i    = {32'h104, 32'h100};
        step();
        check("g0 count", 64'(bus.count_o), 64'd2);
        check("g0 out_valid", 64'(bus.out_valid_o), 64'd3);
        check("l0 pc", 64'(b0[108:77]), 64'h100);
        check("l0 imm_type", 64'(b0[76:74]), 64'd0);
        check("l0 imm", 64'(b0[73:42]), 64'd5);
        check("l0 rd", 64'(b0[31:27]), 64'd1);
        check("l0 wr_reg", 64'(b0[22]), 64'd1);
        check("l0 uses_rs1", 64'(b0[21]), 64'd1);
        check("l0 uses_rs2", 64'(b0[20]), 64'd0);
        check("l0 illegal", 64'(b0[19]), 64'd0);
        check("l1 pc", 64'(b1[108:77]), 64'h104);
        check("l1 rs1", 64'(b1[41:37]), 64'd1);
        check("l1 rs2", 64'(b1[36:32]), 64'd2);
        check("l1 rd", 64'(b1[31:27]), 64'd3);
        check("l1 uses_rs2", 64'(b1[20]), 64'd1);

        // Fill to DEPTH with three more groups
        for (int g = 1; g <= 3; g++) begin
            bus.in_pc_i = {32'h104 + 32'(8 * g), 32'h100 + 32'(8 * g)};
            step();
            check($sformatf("fill%0d count", g), 64'(bus.count_o), 64'(2 + 2 * g));
            check($sformatf("fill%0d in_ready", g), 64'(bus.in_ready_o), (g < 3) ? 64'd1 : 64'd0);
        end
        step();
        check("full hold count", 64'(bus.count_o), 64'd8);
        bus.deq_cnt_i = 2'd2;
        check("full deq-cycle in_ready", 64'(bus.in_ready_o), 64'd0);
        step();
        bus.deq_cnt_i  = 2'd0;
        bus.in_valid_i = 2'b00;
        check("after deq count", 64'(bus.count_o), 64'd6);
        check("after deq in_ready", 64'(bus.in_ready_o), 64'd1);
        check("after deq head pc", 64'(b0[108:77]), 64'h108);
        check("after deq lane1 pc", 64'(b1[108:77]), 64'h10C);

        // Non-contiguous valid is ignored
        bus.in_valid_i = 2'b10;
        step();
        check("noncontig count", 64'(bus.count_o), 64'd6);

        // Kill beats same-cycle enqueue and dequeue
        bus.in_valid_i = 2'b11;
        bus.deq_cnt_i  = 2'd2;
        bus.kill_i     = 1'b1;
        step();
        bus.kill_i     = 1'b0;
        bus.deq_cnt_i  = 2'd0;
        check("kill count", 64'(bus.count_o), 64'd0);
        check("kill out_valid", 64'(bus.out_valid_o), 64'd0);
        check("kill in_ready", 64'(bus.in_ready_o), 64'd1);

        // Over-request dequeue clamps at zero
        bus.in_valid_i = 2'b01;
        bus.in_pc_i    = {32'h0, 32'h200};
        step();
        check("one entry count", 64'(bus.count_o), 64'd1);
        check("one entry out_valid", 64'(bus.out_valid_o), 64'd1);
        check("one entry pc", 64'(b0[108:77]), 64'h200);
        bus.in_valid_i = 2'b00;
        bus.deq_cnt_i  = 2'd2;
        step();
        check("clamp count", 64'(bus.count_o), 64'd0);
        check("clamp out_valid", 64'(bus.out_valid_o), 64'd0);

        // Streaming one in, one out, with pointer wrap
        bus.in_valid_i = 2'b01;
        bus.deq_cnt_i  = 2'd1;
        for (int i = 0; i < 20; i++) begin
            bus.in_pc_i = {32'h0, 32'(4 * i)};
            step();
            check($sformatf("stream%0d count", i), 64'(bus.count_o), 64'd1);
            check($sformatf("stream%0d pc", i), 64'(b0[108:77]), 64'(4 * i));
        end
        bus.in_valid_i = 2'b00;
        step();
        bus.deq_cnt_i = 2'd0;
        check("drain count", 64'(bus.count_o), 64'd0);
        bus.in_valid_i = 2'b10;
        step();
        check("noncontig empty count", 64'(bus.count_o), 64'd0);

        // Asynchronous reset mid-run
        bus.in_valid_i = 2'b11;
        step();
        check("pre-reset count", 64'(bus.count_o), 64'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset count", 64'(bus.count_o), 64'd0);
        check("async reset out_valid", 64'(bus.out_valid_o), 64'd0);
        check("async reset stall", 64'(bus.stall_cycles_o), 64'd0);
        check("async reset empty", 64'(bus.empty_cycles_o), 64'd0);
        #2;
        rst_n = 1'b1;

        // Fill then hold a full queue with a waiting group for 5 cycles
        for (int i = 0; i < 9; i++) step();
        check("perf full count", 64'(bus.count_o), 64'd8);
`ifdef DECODE_QUEUE_PERF_EN
        check("perf stall", 64'(bus.stall_cycles_o), 64'd5);
        check("perf empty", 64'(bus.empty_cycles_o), 64'd1);
`else
        check("perf stall tied", 64'(bus.stall_cycles_o), 64'd0);
        check("perf empty tied", 64'(bus.empty_cycles_o), 64'd0);
`endif
        bus.in_valid_i = 2'b00;
        bus.kill_i     = 1'b1;
        step();
        bus.kill_i = 1'b0;
        check("perf flush count", 64'(bus.count_o), 64'd0);
        for (int i = 0; i < 3; i++) step();
`ifdef DECODE_QUEUE_PERF_EN
        check("perf stall kept", 64'(bus.stall_cycles_o), 64'd5);
        check("perf empty +3", 64'(bus.empty_cycles_o), 64'd4);
`else
        check("perf empty tied idle", 64'(bus.empty_cycles_o), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Parametrised successor to the single-lane ID pipeline register. It decodes up to DEC_WIDTH instructions per cycle using per-lane Decoder and ImmDecoder instances, then packs each result into a bundle. Bundles go into a circular queue of DEPTH entries with valid/ready handshakes on both sides. It sits between IF and DP, and replaces fixed stall/kill registering with credit-free, occupancy-based flow control.

Parameters:
DEC_WIDTH, 2, decode lanes per cycle; enqueue and dequeue width (1..4).
DEPTH, 8, queue entries; power of 2, >= 2*DEC_WIDTH.
ADDR_W, 32, PC width carried in each bundle.

Ports:
clk_i  in  1  clock, rising edge.
reset_i  in  1  asynchronous, active-low reset.
kill_i  in  1  synchronous flush (misprediction/exception).
in_valid_i  in  DEC_WIDTH  per-lane instruction valid; lane 0 is oldest.
in_inst_i  in  DEC_WIDTH*32  per-lane instruction; lane k at bits [32k+31:32k].
in_pc_i  in  DEC_WIDTH*ADDR_W  per-lane PC.
in_ready_o  out  1  queue accepts a full group this cycle.
out_valid_o  out  DEC_WIDTH  bit k set: queue holds at least k+1 entries.
out_bundle_o  out  DEC_WIDTH*BUNDLE_W  oldest DEC_WIDTH bundles; lane 0 = head.
deq_cnt_i  in  $clog2(DEC_WIDTH+1)  bundles DP consumes this cycle.
count_o  out  $clog2(DEPTH+1)  current occupancy.
stall_cycles_o  out  32  perf counter (optional feature).
empty_cycles_o  out  32  perf counter (optional feature).

Behaviour:
- Reset (reset_i low, asynchronous):
  - head, tail, count = 0; out_valid_o = 0; in_ready_o = 1.
  - Bundle storage is not reset; out_bundle_o is don't-care while its valid bit is 0.
  - Reset mid-operation discards all entries.
- Bundle packing:
  - BUNDLE_W is a localparam equal to the sum of the field widths.
  - Order MSB to LSB: pc, imm_type, imm, rs1, rs2, rd, src_a_sel, src_b_sel, wr_reg, uses_rs1, uses_rs2, illegal_instruction, alu_op, rs_ent, dmem_size, dmem_type, md_req_op, md_req_in_1_signed, md_req_in_2_signed, md_req_out_sel.
- Enqueue:
  - n_enq = number of contiguous set bits of in_valid_i starting at lane 0. Lanes after the first 0 are ignored.
  - The enqueue fires when in_ready_o && n_enq > 0.
  - Lane k is written at (tail+k) mod DEPTH; tail advances by n_enq.
- in_ready_o = (DEPTH - count) >= DEC_WIDTH.
  - Computed from registered count only. Space freed by a same-cycle dequeue does not raise in_ready_o until the next cycle.
- Latency: an enqueued bundle appears on out_bundle_o/out_valid_o on the cycle after the accepting edge. There is no bypass.
- Dequeue:
  - n_deq = min(deq_cnt_i, count, DEC_WIDTH).
  - head advances by n_deq; excess deq_cnt_i is silently clamped.
- Simultaneous enqueue and dequeue: count_next = count + n_enq*fire - n_deq. Count never exceeds DEPTH and never underflows.
- Pointer wrap: head and tail are log2(DEPTH) bits and wrap modulo DEPTH. A full queue is identified by count == DEPTH, not by pointer equality.
- out_bundle_o lane k = entry (head+k) mod DEPTH.
- kill_i: on the next edge head = tail = count = 0. It has priority over any same-cycle enqueue and dequeue, and the in-flight group is dropped.
- The decoders are purely combinational on in_inst_i. No state is held outside the queue.

Optional Feature:
DECODE_QUEUE_PERF_EN
- Defined:
  - stall_cycles_o increments on each cycle with in_valid_i[0] && !in_ready_o && !kill_i.
  - empty_cycles_o increments on each cycle with count == 0.
  - Both counters reset to 0, are not cleared by kill_i, and wrap at 2^32.
- Undefined: both outputs are tied to 0 and no counter flops are synthesised.

Test Plan:
All scenarios use DEC_WIDTH=2, DEPTH=8.
1. Reset, then enqueue a group with in_valid_i=2'b11: lane0 ADDI x1,x0,5 (0x00500093), lane1 ADD x3,x1,x2 (0x002081B3), deq_cnt_i=0.
   -> Next cycle: count_o=2, out_valid_o=2'b11.
   -> Lane0 bundle: rd=1, imm=5, uses_rs1=1, uses_rs2=0, wr_reg=1.
   -> Lane1 bundle: rs1=1, rs2=2, rd=3.
2. Four full groups with no dequeue.
   -> count_o goes 2,4,6,8; in_ready_o drops once count_o=8 (accepting edge at count=6).
   -> With count=8, a deq_cnt_i=2 cycle still shows in_ready_o=0 that cycle; in_ready_o=1 the cycle after.
3. Enqueue 1 and dequeue 1 every cycle for 20 cycles (in_valid_i=2'b01, deq_cnt_i=1).
   -> count_o stays 1; head and tail wrap twice.
   -> PCs emerge in order 0x0,0x4,...
4. Non-contiguous in_valid_i=2'b10.
   -> Nothing is enqueued; count_o unchanged.
5. Queue at count=6; same cycle: enqueue 2, deq_cnt_i=2, kill_i=1.
   -> Next cycle: count_o=0, out_valid_o=0, in_ready_o=1.
   -> Also: deq_cnt_i=2 with count=1 yields count_o=0, no underflow.
6. With DECODE_QUEUE_PERF_EN, hold a full queue with in_valid_i=2'b11 for 5 cycles.
   -> stall_cycles_o=5.
   -> After flush, 3 idle cycles give empty_cycles_o +3.
   -> async reset_i=0 mid-run zeroes both counters immediately.
